// File: rtl/pong_pkg.sv
// Shared definitions for the pong game: set-time FSM encoding, timing defaults, clock rate.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EDIT      = 2'd1,
    ST_CONFIRMED = 2'd2
  } set_state_e;

  localparam int unsigned TIME_W      = 8;
  localparam int unsigned CLK_HZ      = 50_000_000;

  localparam int unsigned STEP_SEC    = 15;
  localparam int unsigned MIN_SEC     = 15;
  localparam int unsigned MAX_SEC     = 240;
  localparam int unsigned DEFAULT_SEC = 60;

  // Hold 0.5 s before auto-repeat, then step every 0.1 s.
  localparam int unsigned REPEAT_DELAY_CYC  = CLK_HZ / 2;
  localparam int unsigned REPEAT_PERIOD_CYC = CLK_HZ / 10;

endpackage

// File: rtl/btn_repeat.sv
// Per-direction button front end: rising-edge detect plus optional hold-to-repeat.
// Optional feature macro: SET_TIME_AUTOREPEAT_EN (hold counter present when defined).
module btn_repeat
  import pong_pkg::*;
#(
  parameter int unsigned DELAY  = REPEAT_DELAY_CYC,
  parameter int unsigned PERIOD = REPEAT_PERIOD_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_active,
`ifdef SET_TIME_AUTOREPEAT_EN
  input  logic i_other,
`endif
  output logic o_step_c
);

  if (PERIOD == 0 || PERIOD > DELAY) begin : g_bad_repeat
    $error("btn_repeat: PERIOD must be nonzero and not exceed DELAY");
  end

  logic r_btn_q;
  logic w_rise;

  // Button history register, updated every cycle regardless of state.
  always_ff @(posedge clk) begin
    if (!rst_n) r_btn_q <= 1'b0;
    else        r_btn_q <= i_btn;
  end

  assign w_rise = i_btn & ~r_btn_q;

`ifdef SET_TIME_AUTOREPEAT_EN
  localparam int unsigned CNT_W = $clog2(DELAY + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_armed;
  logic             w_hold;
  logic             w_fire;

  // Counting only continues for a hold that began with a rise inside EDIT.
  assign w_hold    = i_active & i_btn & ~i_other & (w_rise | r_armed);
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_fire    = w_hold & (w_cnt_nxt == CNT_W'(DELAY));

  // Hold counter: reload after each repeat so the next one lands PERIOD cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= w_hold;
      if (!w_hold)     r_cnt <= '0;
      else if (w_fire) r_cnt <= CNT_W'(DELAY - PERIOD);
      else             r_cnt <= w_cnt_nxt;
    end
  end

  assign o_step_c = (i_active & w_rise) | w_fire;
`else
  assign o_step_c = i_active & w_rise;
`endif

endmodule

// File: rtl/set_time_ctrl.sv
// Match-length setter: button presses adjust max_time (seconds) with clamping; ok confirms.
// Optional feature macro: SET_TIME_AUTOREPEAT_EN (hold-to-repeat on up/down).
module set_time_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned STEP          = STEP_SEC,
  parameter int unsigned MIN_TIME      = MIN_SEC,
  parameter int unsigned MAX_TIME      = MAX_SEC,
  parameter int unsigned DEFAULT_TIME  = DEFAULT_SEC,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_CYC,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_ok,
  output logic [TIME_W-1:0] max_time,
  output logic              editing,
  output logic              time_valid,
  output logic              confirm
);

  localparam int unsigned SUM_W = TIME_W + 1;

  if (STEP == 0 || MAX_TIME > 255 || (MAX_TIME % STEP) != 0 || (DEFAULT_TIME % STEP) != 0 ||
      DEFAULT_TIME < MIN_TIME || DEFAULT_TIME > MAX_TIME) begin : g_bad_cfg
    $error("set_time_ctrl: inconsistent time parameters");
  end

  set_state_e        r_state;
  logic [TIME_W-1:0] r_max;
  logic              r_editing;
  logic              r_valid;
  logic              r_confirm;
  logic              r_ok_q;

  logic              w_active;
  logic              w_up_step;
  logic              w_dn_step;
  logic              w_rise_ok;
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_floor;
  logic [TIME_W-1:0] w_inc;
  logic [TIME_W-1:0] w_dec;

  assign w_active = (r_state == ST_EDIT);

  btn_repeat #(.DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) u_rep_up (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_btn    (btn_up),
    .i_active (w_active),
`ifdef SET_TIME_AUTOREPEAT_EN
    .i_other  (btn_down),
`endif
    .o_step_c (w_up_step)
  );

  btn_repeat #(.DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) u_rep_dn (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_btn    (btn_down),
    .i_active (w_active),
`ifdef SET_TIME_AUTOREPEAT_EN
    .i_other  (btn_up),
`endif
    .o_step_c (w_dn_step)
  );

  assign w_rise_ok = btn_ok & ~r_ok_q;

  // Saturating step arithmetic, one bit wider so the top clamp never wraps.
  assign w_sum   = {1'b0, r_max} + SUM_W'(STEP);
  assign w_inc   = (w_sum > SUM_W'(MAX_TIME)) ? TIME_W'(MAX_TIME) : w_sum[TIME_W-1:0];
  assign w_floor = SUM_W'(MIN_TIME) + SUM_W'(STEP);
  assign w_dec   = ({1'b0, r_max} < w_floor) ? TIME_W'(MIN_TIME) : (r_max - TIME_W'(STEP));

  // Set-time FSM with registered outputs; ok wins over up/down, enable low wins over all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_max     <= TIME_W'(DEFAULT_TIME);
      r_editing <= 1'b0;
      r_valid   <= 1'b0;
      r_confirm <= 1'b0;
      r_ok_q    <= 1'b0;
    end else begin
      r_ok_q    <= btn_ok;
      r_confirm <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state   <= ST_EDIT;
            r_editing <= 1'b1;
          end
        end
        ST_EDIT: begin
          if (!enable) begin
            r_state   <= ST_IDLE;
            r_editing <= 1'b0;
          end else if (w_rise_ok) begin
            r_state   <= ST_CONFIRMED;
            r_editing <= 1'b0;
            r_valid   <= 1'b1;
            r_confirm <= 1'b1;
          end else if (w_up_step && !w_dn_step) begin
            r_max <= w_inc;
          end else if (w_dn_step && !w_up_step) begin
            r_max <= w_dec;
          end
        end
        ST_CONFIRMED: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_editing <= 1'b0;
          r_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign max_time   = r_max;
  assign editing    = r_editing;
  assign time_valid = r_valid;
  assign confirm    = r_confirm;

endmodule
